ex_stage: RTL and testbench
===========================

// Module: ex_stage
// PURPOSE
//  Execute stage of the 5-stage RV32I pipeline, fed by the ID/EX pipeline register.
//  - Selects forwarded operands and runs the ALU.
//  - Resolves the branch condition and computes the branch target.
//  - Registers all results into an internal EX/MEM pipeline register that feeds the MEM stage.
//  - Branch redirect is issued from the MEM side (registered branch_taken_mem).
// PARAMETERS
//  XLEN  32  datapath width; only 32 is supported
// PORTS
//  clk            in   1     clock; all state updates on posedge
//  reset          in   1     synchronous, active-high
//  write          in   1     EX/MEM register load enable (0 = hold, used for stall)
//  flush          in   1     load a bubble into EX/MEM (branch taken / hazard)
//  pc_ex          in   32    PC of the instruction in EX
//  MemRead/MemtoReg/MemWrite/RegWrite/Branch/ALUSrc  in  1 each  controls from ID/EX
//  ALUop          in   2     00 add, 01 branch compare, 10 funct-decoded, 11 pass B
//  imm_ex         in   32    sign-extended immediate
//  rs1_data/rs2_data  in  32 register operands from ID/EX
//  funct3/funct7/opcode  in  3/7/7  instruction fields
//  rd_ex          in   5     destination register
//  forward_a/forward_b  in  2  00 = reg data, 10 = EX/MEM alu_result_mem, 01 = wb_data, 11 = reg data
//  wb_data        in   32    MEM/WB write-back value (forwarding source)
//  alu_result_mem out  32    registered ALU result
//  store_data_mem out  32    registered forwarded rs2 value (pre-ALUSrc mux)
//  pc_branch_mem  out  32    registered pc_ex + imm_ex
//  branch_taken_mem  out  1  registered Branch & condition true
//  zero_mem       out  1     registered (ALU result == 0)
//  rd_mem         out  5     registered rd
//  funct3_mem     out  3     registered funct3 (load/store width for MEM)
//  MemRead_mem/MemtoReg_mem/MemWrite_mem/RegWrite_mem  out  1  registered controls
// BEHAVIOUR
//  - Reset: every output = 0. Priority: reset > flush > write > hold.
//  - Flush: every output = 0 (bubble: no write, no memory access, no branch).
//  - write=0 and no flush: all outputs hold their values.
//  - Latency: 1 cycle; operands and controls captured on the edge with write=1 appear at the outputs next cycle.
//  - Operand A = fwd(forward_a, rs1_data).
//  - fwdB = fwd(forward_b, rs2_data); operand B = ALUSrc ? imm_ex : fwdB.
//  - Forward source 10 uses the current registered alu_result_mem, not the new value.
//  - ALUop 00: A+B. ALUop 11: B (LUI).
//  - ALUop 10, by funct3:
//      000 add; sub when opcode=0110011 & funct7[5]
//      001 sll; 010 slt (signed); 011 sltu
//      100 xor
//      101 srl; sra when funct7[5]
//      110 or; 111 and
//  - Shift amount = B[4:0]. Arithmetic is mod 2^32 with no overflow flag. slt/sltu produce 32'd0 or 32'd1.
//  - ALUop 01: result = A-B. Condition by funct3:
//      000 eq, 001 ne, 100 lt signed, 101 ge signed, 110 ltu, 111 geu
//      010 and 011 -> condition false
//  - branch_taken_mem = Branch & cond. Branch=1 with ALUop!=01 -> not taken.
//  - pc_branch_mem = pc_ex + imm_ex, always computed and wraps mod 2^32.
//  - Simultaneous flush and write: flush wins.
//  - Reset asserted mid-stall: outputs clear; the held instruction is lost by design.
// STRUCTURE
//  - Package ex_pkg:
//      ALUop codes (ALUOP_ADD/BRANCH/FUNCT/PASSB)
//      forward selects (FWD_REG/FWD_MEM/FWD_WB)
//      funct3 constants for ALU ops and branch types
//      OPCODE_RTYPE = 7'b0110011
//  - Sub-module alu_core: purely combinational.
//      inputs: A, B, ALUop, funct3, funct7, opcode
//      outputs: result, zero, branch_cond
//  - ex_stage holds the forwarding muxes, branch adder, and EX/MEM register.
// TESTING
//  1. reset=1 for 2 cycles with random inputs -> all outputs 0. Then write=1, ALUop=00, rs1=5, imm=8, ALUSrc=1 -> alu_result_mem=13 one cycle later.
//  2. ALUop=10, opcode=0110011, funct3=000, funct7=0100000, rs1=3, rs2=5 -> alu_result_mem=32'hFFFF_FFFE. Same with funct3=101 and rs1=32'h8000_0000, rs2=4 -> 32'hF800_0000.
//  3. Branch=1, ALUop=01, funct3=100, rs1=-1, rs2=1, pc=0x100, imm=-16 -> branch_taken_mem=1, pc_branch_mem=0xF0. Same with funct3=110 -> branch_taken_mem=0.
//  4. Forwarding: previous result alu_result_mem=0x55, forward_a=10, wb_data=0x11, forward_b=01, ALUop=00, ALUSrc=0 -> alu_result_mem=0x66.
//  5. Stall/flush: write=0 for 3 cycles -> outputs hold. Then flush=1 together with write=1 and RegWrite=1 -> RegWrite_mem=0, all outputs 0.
//  6. Store path: MemWrite=1, ALUSrc=1, forward_b=01, wb_data=0xAB -> store_data_mem=0xAB, MemWrite_mem=1, alu_result_mem=rs1+imm.

Source files
------------

// File: rtl/ex_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ex_pkg
//  Description : Shared encodings for the RV32I execute stage: ALU operation
//                classes, forwarding selects, funct3 codes for ALU and branch
//                instructions, the R-type opcode, the EX/MEM register layout
//                and the forwarding-mux helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package ex_pkg;

    // ALU operation class driven by the decoder
    localparam logic [1:0] ALUOP_ADD    = 2'b00;
    localparam logic [1:0] ALUOP_BRANCH = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT  = 2'b10;
    localparam logic [1:0] ALUOP_PASSB  = 2'b11;

    // Forwarding selects (2'b11 falls back to register data)
    localparam logic [1:0] FWD_REG = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b10;
    localparam logic [1:0] FWD_WB  = 2'b01;

    // funct3 for register/immediate ALU operations
    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_SLL     = 3'b001;
    localparam logic [2:0] F3_SLT     = 3'b010;
    localparam logic [2:0] F3_SLTU    = 3'b011;
    localparam logic [2:0] F3_XOR     = 3'b100;
    localparam logic [2:0] F3_SRL_SRA = 3'b101;
    localparam logic [2:0] F3_OR      = 3'b110;
    localparam logic [2:0] F3_AND     = 3'b111;

    // funct3 for conditional branches
    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    localparam logic [6:0] OPCODE_RTYPE = 7'b0110011;

    // Contents of the EX/MEM pipeline register
    typedef struct packed {
        logic [31:0] alu_result;
        logic [31:0] store_data;
        logic [31:0] pc_branch;
        logic        branch_taken;
        logic        zero;
        logic [4:0]  rd;
        logic [2:0]  funct3;
        logic        mem_read;
        logic        mem_to_reg;
        logic        mem_write;
        logic        reg_write;
    } ex_mem_t;

    // Operand forwarding mux shared by both ALU inputs
    function automatic logic [31:0] fwd_select(
        input logic [1:0]  sel,
        input logic [31:0] reg_val,
        input logic [31:0] mem_val,
        input logic [31:0] wb_val
    );
        logic [31:0] v;
        case (sel)
            FWD_MEM: v = mem_val;
            FWD_WB:  v = wb_val;
            default: v = reg_val;
        endcase
        return v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/alu_core.sv
`default_nettype none
// ============================================================================
//  Module      : alu_core
//  Description : Purely combinational RV32I ALU and branch comparator.
//                Ports:
//                  A, B          32-bit operands
//                  ALUop         operation class (add / branch / funct / pass B)
//                  funct3/funct7 instruction function fields
//                  opcode        distinguishes R-type sub from addi
//                  result        32-bit ALU result
//                  zero          result == 0
//                  branch_cond   branch condition (valid only for ALUop=01)
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_core
    import ex_pkg::*;
(
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic [1:0]  ALUop,
    input  logic [2:0]  funct3,
    input  logic [6:0]  funct7,
    input  logic [6:0]  opcode,
    output logic [31:0] result,
    output logic        zero,
    output logic        branch_cond
);

    logic [31:0] w_sum;
    logic [31:0] w_diff;
    logic [4:0]  w_shamt;
    logic        w_lt_signed;
    logic        w_lt_unsigned;
    logic        w_is_sub;
    logic        w_unused_funct7;

    assign w_sum         = A + B;
    assign w_diff        = A - B;
    assign w_shamt       = B[4:0];
    assign w_lt_signed   = $signed(A) < $signed(B);
    assign w_lt_unsigned = A < B;
    // funct7[5] selects sub only for register-register ops; for addi those
    // bits belong to the immediate.
    assign w_is_sub      = (opcode == OPCODE_RTYPE) && funct7[5];

    // Only funct7[5] carries meaning for RV32I base ALU operations
    assign w_unused_funct7 = ^{funct7[6], funct7[4:0]};

    always_comb begin
        result      = '0;
        branch_cond = 1'b0;
        case (ALUop)
            ALUOP_ADD:   result = w_sum;
            ALUOP_PASSB: result = B;
            ALUOP_BRANCH: begin
                result = w_diff;
                case (funct3)
                    F3_BEQ:  branch_cond = (A == B);
                    F3_BNE:  branch_cond = (A != B);
                    F3_BLT:  branch_cond = w_lt_signed;
                    F3_BGE:  branch_cond = ~w_lt_signed;
                    F3_BLTU: branch_cond = w_lt_unsigned;
                    F3_BGEU: branch_cond = ~w_lt_unsigned;
                    default: branch_cond = 1'b0;
                endcase
            end
            ALUOP_FUNCT: begin
                case (funct3)
                    F3_ADD_SUB: result = w_is_sub ? w_diff : w_sum;
                    F3_SLL:     result = A << w_shamt;
                    F3_SLT:     result = {31'd0, w_lt_signed};
                    F3_SLTU:    result = {31'd0, w_lt_unsigned};
                    F3_XOR:     result = A ^ B;
                    F3_SRL_SRA: result = funct7[5] ? 32'($signed(A) >>> w_shamt)
                                                   : (A >> w_shamt);
                    F3_OR:      result = A | B;
                    F3_AND:     result = A & B;
                    default:    result = '0;
                endcase
            end
            default: result = '0;
        endcase
    end

    assign zero = (result == 32'd0);

endmodule
`default_nettype wire

// File: rtl/ex_stage.sv
`default_nettype none
// ============================================================================
//  Module      : ex_stage
//  Description : Execute stage of the 5-stage RV32I pipeline. Selects the
//                forwarded operands, runs the ALU, resolves the branch
//                condition, computes pc_ex + imm_ex and registers everything
//                into the EX/MEM pipeline register.
//                Ports:
//                  clk, reset     clock, synchronous active-high reset
//                  write, flush   EX/MEM load enable / bubble insert
//                  pc_ex, imm_ex, rs1_data, rs2_data, funct3/7, opcode, rd_ex
//                                 instruction data from ID/EX
//                  MemRead..ALUSrc, ALUop  decoded controls from ID/EX
//                  forward_a/b, wb_data    forwarding selects and WB source
//                  *_mem outputs  registered EX/MEM contents
//  Revision    : 1.0 - initial release
// ============================================================================
module ex_stage
    import ex_pkg::*;
#(
    parameter int XLEN = 32   // only 32 is supported
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            write,
    input  logic            flush,
    input  logic [XLEN-1:0] pc_ex,
    input  logic            MemRead,
    input  logic            MemtoReg,
    input  logic            MemWrite,
    input  logic            RegWrite,
    input  logic            Branch,
    input  logic            ALUSrc,
    input  logic [1:0]      ALUop,
    input  logic [XLEN-1:0] imm_ex,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    input  logic [2:0]      funct3,
    input  logic [6:0]      funct7,
    input  logic [6:0]      opcode,
    input  logic [4:0]      rd_ex,
    input  logic [1:0]      forward_a,
    input  logic [1:0]      forward_b,
    input  logic [XLEN-1:0] wb_data,
    output logic [XLEN-1:0] alu_result_mem,
    output logic [XLEN-1:0] store_data_mem,
    output logic [XLEN-1:0] pc_branch_mem,
    output logic            branch_taken_mem,
    output logic            zero_mem,
    output logic [4:0]      rd_mem,
    output logic [2:0]      funct3_mem,
    output logic            MemRead_mem,
    output logic            MemtoReg_mem,
    output logic            MemWrite_mem,
    output logic            RegWrite_mem
);

    ex_mem_t     r_exmem;
    ex_mem_t     w_exmem_next;

    logic [31:0] w_op_a;
    logic [31:0] w_fwd_b;
    logic [31:0] w_op_b;
    logic [31:0] w_alu_result;
    logic        w_alu_zero;
    logic        w_branch_cond;
    logic        w_branch_taken;
    logic [31:0] w_pc_branch;

    // The MEM-stage forward path taps the value already held in EX/MEM,
    // i.e. the result of the instruction immediately ahead of this one.
    assign w_op_a  = fwd_select(forward_a, rs1_data, r_exmem.alu_result, wb_data);
    assign w_fwd_b = fwd_select(forward_b, rs2_data, r_exmem.alu_result, wb_data);
    assign w_op_b  = ALUSrc ? imm_ex : w_fwd_b;

    alu_core u_alu_core (
        .A           (w_op_a),
        .B           (w_op_b),
        .ALUop       (ALUop),
        .funct3      (funct3),
        .funct7      (funct7),
        .opcode      (opcode),
        .result      (w_alu_result),
        .zero        (w_alu_zero),
        .branch_cond (w_branch_cond)
    );

    // Only a genuine branch-compare operation may redirect the PC
    assign w_branch_taken = Branch && (ALUop == ALUOP_BRANCH) && w_branch_cond;
    assign w_pc_branch    = pc_ex + imm_ex;

    always_comb begin
        w_exmem_next              = '0;
        w_exmem_next.alu_result   = w_alu_result;
        // Stores take the forwarded rs2 before the immediate mux
        w_exmem_next.store_data   = w_fwd_b;
        w_exmem_next.pc_branch    = w_pc_branch;
        w_exmem_next.branch_taken = w_branch_taken;
        w_exmem_next.zero         = w_alu_zero;
        w_exmem_next.rd           = rd_ex;
        w_exmem_next.funct3       = funct3;
        w_exmem_next.mem_read     = MemRead;
        w_exmem_next.mem_to_reg   = MemtoReg;
        w_exmem_next.mem_write    = MemWrite;
        w_exmem_next.reg_write    = RegWrite;
    end

    // A flush clears the whole register so the bubble can never write,
    // access memory or redirect the PC.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_exmem <= '0;
        end else if (flush) begin
            r_exmem <= '0;
        end else if (write) begin
            r_exmem <= w_exmem_next;
        end
    end

    assign alu_result_mem   = r_exmem.alu_result;
    assign store_data_mem   = r_exmem.store_data;
    assign pc_branch_mem    = r_exmem.pc_branch;
    assign branch_taken_mem = r_exmem.branch_taken;
    assign zero_mem         = r_exmem.zero;
    assign rd_mem           = r_exmem.rd;
    assign funct3_mem       = r_exmem.funct3;
    assign MemRead_mem      = r_exmem.mem_read;
    assign MemtoReg_mem     = r_exmem.mem_to_reg;
    assign MemWrite_mem     = r_exmem.mem_write;
    assign RegWrite_mem     = r_exmem.reg_write;

endmodule
`default_nettype wire

// File: tb/tb_ex_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ex_stage
//  Description : Scoreboard testbench for ex_stage. Stimulus pushes the
//                hand-computed EX/MEM contents expected one cycle later; a
//                monitor pops and compares after each checked edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ex_stage;

    logic        clk;
    logic        reset;
    logic        write;
    logic        flush;
    logic [31:0] pc_ex;
    logic        MemRead, MemtoReg, MemWrite, RegWrite, Branch, ALUSrc;
    logic [1:0]  ALUop;
    logic [31:0] imm_ex, rs1_data, rs2_data, wb_data;
    logic [2:0]  funct3;
    logic [6:0]  funct7, opcode;
    logic [4:0]  rd_ex;
    logic [1:0]  forward_a, forward_b;
    logic [31:0] alu_result_mem, store_data_mem, pc_branch_mem;
    logic        branch_taken_mem, zero_mem;
    logic [4:0]  rd_mem;
    logic [2:0]  funct3_mem;
    logic        MemRead_mem, MemtoReg_mem, MemWrite_mem, RegWrite_mem;

    ex_stage #(.XLEN(32)) dut (
        .clk(clk), .reset(reset), .write(write), .flush(flush), .pc_ex(pc_ex),
        .MemRead(MemRead), .MemtoReg(MemtoReg), .MemWrite(MemWrite),
        .RegWrite(RegWrite), .Branch(Branch), .ALUSrc(ALUSrc), .ALUop(ALUop),
        .imm_ex(imm_ex), .rs1_data(rs1_data), .rs2_data(rs2_data),
        .funct3(funct3), .funct7(funct7), .opcode(opcode), .rd_ex(rd_ex),
        .forward_a(forward_a), .forward_b(forward_b), .wb_data(wb_data),
        .alu_result_mem(alu_result_mem), .store_data_mem(store_data_mem),
        .pc_branch_mem(pc_branch_mem), .branch_taken_mem(branch_taken_mem),
        .zero_mem(zero_mem), .rd_mem(rd_mem), .funct3_mem(funct3_mem),
        .MemRead_mem(MemRead_mem), .MemtoReg_mem(MemtoReg_mem),
        .MemWrite_mem(MemWrite_mem), .RegWrite_mem(RegWrite_mem)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic        reset, write, flush;
        logic [31:0] pc;
        logic        mr, mtr, mw, rw, br, alusrc;
        logic [1:0]  aluop;
        logic [31:0] imm, rs1, rs2, wb;
        logic [2:0]  f3;
        logic [6:0]  f7, opc;
        logic [4:0]  rd;
        logic [1:0]  fa, fb;
    } vec_t;

    typedef struct {
        logic [31:0] alu, store, pcb;
        logic        taken, zero;
        logic [4:0]  rd;
        logic [2:0]  f3;
        logic [3:0]  ctl;   // {MemRead, MemtoReg, MemWrite, RegWrite}
    } out_t;

    out_t  exp_q[$];
    string tag_q[$];
    out_t  last_exp;
    out_t  zero_exp;
    logic  chk;
    int    total;
    int    bad;

    function automatic vec_t base();
        vec_t v;
        v = '{default: '0};
        v.write = 1'b1;
        return v;
    endfunction

    function automatic out_t mk(input logic [31:0] alu, input logic [31:0] store,
                                input logic [31:0] pcb, input logic taken,
                                input logic z, input logic [4:0] rd,
                                input logic [2:0] f3, input logic [3:0] ctl);
        out_t o;
        o.alu = alu; o.store = store; o.pcb = pcb; o.taken = taken;
        o.zero = z; o.rd = rd; o.f3 = f3; o.ctl = ctl;
        return o;
    endfunction

    task automatic cmp(input string tag, input string f,
                       input logic [31:0] a, input logic [31:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s.%s got=%h want=%h", tag, f, a, e);
        end
    endtask

    task automatic apply(input vec_t v);
        reset = v.reset; write = v.write; flush = v.flush; pc_ex = v.pc;
        MemRead = v.mr; MemtoReg = v.mtr; MemWrite = v.mw; RegWrite = v.rw;
        Branch = v.br; ALUSrc = v.alusrc; ALUop = v.aluop; imm_ex = v.imm;
        rs1_data = v.rs1; rs2_data = v.rs2; wb_data = v.wb; funct3 = v.f3;
        funct7 = v.f7; opcode = v.opc; rd_ex = v.rd;
        forward_a = v.fa; forward_b = v.fb;
    endtask

    task automatic step(input string tag, input vec_t v, input out_t e, input bit check);
        @(negedge clk);
        apply(v);
        chk = check;
        if (check) begin
            exp_q.push_back(e);
            tag_q.push_back(tag);
        end
    endtask

    // Normal load: expectation becomes the new held state
    task automatic go(input string tag, input vec_t v, input out_t e);
        step(tag, v, e, 1'b1);
        last_exp = e;
    endtask

    // Stall: inputs may change, EX/MEM must keep the last captured state
    task automatic hold(input string tag, input vec_t v);
        v.write = 1'b0;
        step(tag, v, last_exp, 1'b1);
    endtask

    // Reset or flush: everything clears
    task automatic bubble(input string tag, input vec_t v);
        step(tag, v, zero_exp, 1'b1);
        last_exp = zero_exp;
    endtask

    function automatic vec_t rand_vec();
        vec_t v;
        v = base();
        v.write = 1'($urandom); v.flush = 1'($urandom); v.pc = $urandom;
        v.mr = 1'($urandom); v.mtr = 1'($urandom); v.mw = 1'($urandom);
        v.rw = 1'($urandom); v.br = 1'($urandom); v.alusrc = 1'($urandom);
        v.aluop = 2'($urandom); v.imm = $urandom; v.rs1 = $urandom;
        v.rs2 = $urandom; v.wb = $urandom; v.f3 = 3'($urandom);
        v.f7 = 7'($urandom); v.opc = 7'($urandom); v.rd = 5'($urandom);
        v.fa = 2'($urandom); v.fb = 2'($urandom);
        return v;
    endfunction

    // Monitor: after every edge that captured a checked vector, compare.
    initial begin : monitor
        bit    c;
        out_t  e;
        string t;
        forever begin
            @(posedge clk);
            c = chk;
            #1;
            if (c) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL scoreboard got=empty want=entry");
                end else begin
                    e = exp_q.pop_front();
                    t = tag_q.pop_front();
                    cmp(t, "alu_result", alu_result_mem, e.alu);
                    cmp(t, "store_data", store_data_mem, e.store);
                    cmp(t, "pc_branch",  pc_branch_mem,  e.pcb);
                    cmp(t, "taken",      32'(branch_taken_mem), 32'(e.taken));
                    cmp(t, "zero",       32'(zero_mem),   32'(e.zero));
                    cmp(t, "rd",         32'(rd_mem),     32'(e.rd));
                    cmp(t, "funct3",     32'(funct3_mem), 32'(e.f3));
                    cmp(t, "ctl",
                        32'({MemRead_mem, MemtoReg_mem, MemWrite_mem, RegWrite_mem}),
                        32'(e.ctl));
                end
            end
        end
    end

    initial begin : stim
        vec_t v;
        total    = 0;
        bad      = 0;
        chk      = 1'b0;
        zero_exp = mk(32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 5'd0, 3'd0, 4'b0000);
        last_exp = zero_exp;
        v = base();
        v.reset = 1'b1;
        apply(v);

        // Reset with random inputs
        for (int i = 0; i < 2; i++) begin
            v = rand_vec();
            v.reset = 1'b1;
            bubble("reset", v);
        end

        // addi: 5 + 8
        v = base(); v.rs1 = 32'd5; v.imm = 32'd8; v.alusrc = 1'b1; v.rs2 = 32'd7;
        v.rd = 5'd1; v.rw = 1'b1;
        go("addi", v, mk(32'd13, 32'd7, 32'd8, 1'b0, 1'b0, 5'd1, 3'd0, 4'b0001));

        // sub: 3 - 5
        v = base(); v.aluop = 2'b10; v.opc = 7'b0110011; v.f7 = 7'b0100000;
        v.rs1 = 32'd3; v.rs2 = 32'd5; v.pc = 32'd4; v.rd = 5'd2; v.rw = 1'b1;
        go("sub", v, mk(32'hFFFF_FFFE, 32'd5, 32'd4, 1'b0, 1'b0, 5'd2, 3'd0, 4'b0001));

        // sra / srl of 0x8000_0000 by 4
        v.f3 = 3'b101; v.rs1 = 32'h8000_0000; v.rs2 = 32'd4; v.pc = 32'd8; v.rd = 5'd3;
        go("sra", v, mk(32'hF800_0000, 32'd4, 32'd8, 1'b0, 1'b0, 5'd3, 3'd5, 4'b0001));
        v.f7 = 7'b0000000;
        go("srl", v, mk(32'h0800_0000, 32'd4, 32'd8, 1'b0, 1'b0, 5'd3, 3'd5, 4'b0001));

        // slt / sltu of -1 vs 1
        v = base(); v.aluop = 2'b10; v.opc = 7'b0110011; v.f3 = 3'b010;
        v.rs1 = 32'hFFFF_FFFF; v.rs2 = 32'd1; v.rd = 5'd4; v.rw = 1'b1;
        go("slt", v, mk(32'd1, 32'd1, 32'd0, 1'b0, 1'b0, 5'd4, 3'd2, 4'b0001));
        v.f3 = 3'b011;
        go("sltu", v, mk(32'd0, 32'd1, 32'd0, 1'b0, 1'b1, 5'd4, 3'd3, 4'b0001));

        // addi whose immediate has bit 30 set: still an add
        v = base(); v.aluop = 2'b10; v.opc = 7'b0010011; v.f7 = 7'b0100000;
        v.alusrc = 1'b1; v.imm = 32'h400; v.rs1 = 32'h10; v.rd = 5'd5; v.rw = 1'b1;
        go("addi_f7", v, mk(32'h410, 32'd0, 32'h400, 1'b0, 1'b0, 5'd5, 3'd0, 4'b0001));

        // Branches
        v = base(); v.br = 1'b1; v.aluop = 2'b01; v.f3 = 3'b100;
        v.rs1 = 32'hFFFF_FFFF; v.rs2 = 32'd1; v.pc = 32'h100; v.imm = 32'hFFFF_FFF0;
        go("blt", v, mk(32'hFFFF_FFFE, 32'd1, 32'hF0, 1'b1, 1'b0, 5'd0, 3'd4, 4'b0000));
        v.f3 = 3'b110;
        go("bltu", v, mk(32'hFFFF_FFFE, 32'd1, 32'hF0, 1'b0, 1'b0, 5'd0, 3'd6, 4'b0000));
        v.f3 = 3'b000; v.rs1 = 32'd7; v.rs2 = 32'd7; v.pc = 32'h200; v.imm = 32'd8;
        go("beq", v, mk(32'd0, 32'd7, 32'h208, 1'b1, 1'b1, 5'd0, 3'd0, 4'b0000));
        v.f3 = 3'b010;
        go("br_f3_010", v, mk(32'd0, 32'd7, 32'h208, 1'b0, 1'b1, 5'd0, 3'd2, 4'b0000));
        v = base(); v.br = 1'b1; v.rs1 = 32'd2; v.rs2 = 32'd3;
        go("br_aluop00", v, mk(32'd5, 32'd3, 32'd0, 1'b0, 1'b0, 5'd0, 3'd0, 4'b0000));

        // lui: pass B
        v = base(); v.aluop = 2'b11; v.alusrc = 1'b1; v.imm = 32'h1234_5000;
        v.rs1 = 32'h99; v.rd = 5'd6; v.rw = 1'b1;
        go("lui", v, mk(32'h1234_5000, 32'd0, 32'h1234_5000, 1'b0, 1'b0, 5'd6, 3'd0, 4'b0001));

        // Forwarding from EX/MEM (0x55) and WB (0x11)
        v = base(); v.rs1 = 32'h50; v.imm = 32'd5; v.alusrc = 1'b1; v.rd = 5'd7; v.rw = 1'b1;
        go("prep55", v, mk(32'h55, 32'd0, 32'd5, 1'b0, 1'b0, 5'd7, 3'd0, 4'b0001));
        v = base(); v.fa = 2'b10; v.fb = 2'b01; v.wb = 32'h11; v.rs1 = 32'h999;
        v.rs2 = 32'h777; v.rd = 5'd8; v.rw = 1'b1;
        go("fwd", v, mk(32'h66, 32'h11, 32'd0, 1'b0, 1'b0, 5'd8, 3'd0, 4'b0001));
        v.fa = 2'b11; v.fb = 2'b11; v.rs1 = 32'h20; v.rs2 = 32'h22; v.wb = 32'h1;
        go("fwd11", v, mk(32'h42, 32'h22, 32'd0, 1'b0, 1'b0, 5'd8, 3'd0, 4'b0001));

        // Store path
        v = base(); v.mw = 1'b1; v.alusrc = 1'b1; v.fb = 2'b01; v.wb = 32'hAB;
        v.rs1 = 32'h1000; v.imm = 32'h20; v.rs2 = 32'h5; v.f3 = 3'b010; v.pc = 32'h40;
        go("store", v, mk(32'h1020, 32'hAB, 32'h60, 1'b0, 1'b0, 5'd0, 3'd2, 4'b0010));

        // Stall for three cycles with changing inputs
        for (int i = 0; i < 3; i++) begin
            v = rand_vec();
            v.flush = 1'b0;
            hold("stall", v);
        end

        // Flush beats write
        v = base(); v.flush = 1'b1; v.rw = 1'b1; v.rs1 = 32'h77; v.rd = 5'd9;
        bubble("flush", v);

        // Load whose branch target wraps
        v = base(); v.mr = 1'b1; v.mtr = 1'b1; v.rw = 1'b1; v.alusrc = 1'b1;
        v.rs1 = 32'h2000; v.imm = 32'h20; v.pc = 32'hFFFF_FFF0; v.rd = 5'd9; v.f3 = 3'b010;
        go("load_wrap", v, mk(32'h2020, 32'd0, 32'h10, 1'b0, 1'b0, 5'd9, 3'd2, 4'b1101));
        v = rand_vec(); v.flush = 1'b0;
        hold("stall2", v);
        v = rand_vec(); v.write = 1'b0; v.flush = 1'b0; v.reset = 1'b1;
        bubble("reset_stall", v);

        // Logic ops and shift amount taken from B[4:0]
        v = base(); v.aluop = 2'b10; v.opc = 7'b0110011; v.rs1 = 32'hF0F0;
        v.rs2 = 32'hFF00; v.rd = 5'd10; v.rw = 1'b1; v.f3 = 3'b111;
        go("and", v, mk(32'hF000, 32'hFF00, 32'd0, 1'b0, 1'b0, 5'd10, 3'd7, 4'b0001));
        v.f3 = 3'b110;
        go("or", v, mk(32'hFFF0, 32'hFF00, 32'd0, 1'b0, 1'b0, 5'd10, 3'd6, 4'b0001));
        v.f3 = 3'b100;
        go("xor", v, mk(32'h0FF0, 32'hFF00, 32'd0, 1'b0, 1'b0, 5'd10, 3'd4, 4'b0001));
        v.f3 = 3'b001; v.rs1 = 32'd1; v.rs2 = 32'h21;
        go("sll", v, mk(32'd2, 32'h21, 32'd0, 1'b0, 1'b0, 5'd10, 3'd1, 4'b0001));

        // Drain
        v = base(); v.write = 1'b0;
        step("idle", v, zero_exp, 1'b0);
        repeat (3) @(posedge clk);
        #2;
        cmp("end", "queue_left", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
